sram_1rw1r_responder: RTL and testbench

SRAM_1RW1R_RESPONDER -- requirements
Module: sram_1rw1r_responder

---
 rtl/sram_1rw1r_responder_if.sv | 28 ++
 rtl/sram_1rw1r_responder.sv | 84 ++++++++
 tb/tb_sram_1rw1r_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sram_1rw1r_responder_if.sv
// Bus bundle for the 1RW/1R flop-based SRAM responder: port 0 read/write, port 1 read-only,
// plus clear-in-progress and same-address collision status.
interface sram_1rw1r_responder_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic              csb0;
    logic              web0;
    logic              wmask0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] dout0;
    logic              csb1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] dout1;
    logic              busy;
    logic              collision;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout1, busy, collision
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout1, busy, collision
    );
endinterface

// File: rtl/sram_1rw1r_responder.sv
// Flop-based SRAM with one read/write port and one read-only port; after reset the whole
// array is swept to zero (busy high) before any access is accepted.
module sram_1rw1r_responder #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    sram_1rw1r_responder_if.slave  bus
);
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [0:0]  ST_CLEAR = 1'b0;
    localparam logic [0:0]  ST_READY = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout0;
    logic [DATA_W-1:0] r_dout1;
    logic              r_collision;

    logic w_ready;
    logic w_wr0;
    logic w_rd0;
    logic w_rd1;
    logic w_coll;

    always_comb begin
        w_ready = (r_state == ST_READY);
        w_wr0   = w_ready && !bus.csb0 && !bus.web0 && bus.wmask0;
        w_rd0   = w_ready && !bus.csb0 && bus.web0;
        w_rd1   = w_ready && !bus.csb1;
        w_coll  = w_wr0 && w_rd1 && (bus.addr0 == bus.addr1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
            if (r_clr_ptr == '1) begin
                r_state <= ST_READY;
            end
        end
    end

    // Array has no reset of its own: contents are only zeroed by the CLEAR sweep.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_wr0) begin
                r_mem[bus.addr0] <= bus.din0;
            end
        end
    end

    // Reads sample the array before this edge's write lands, giving old data on a collision.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dout0     <= '0;
            r_dout1     <= '0;
            r_collision <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_dout0     <= '0;
            r_dout1     <= '0;
            r_collision <= 1'b0;
        end else begin
            if (w_rd0) begin
                r_dout0 <= r_mem[bus.addr0];
            end
            if (w_rd1) begin
                r_dout1 <= r_mem[bus.addr1];
            end
            r_collision <= w_coll;
        end
    end

    assign bus.dout0     = r_dout0;
    assign bus.dout1     = r_dout1;
    assign bus.busy      = (r_state == ST_CLEAR);
    assign bus.collision = r_collision;
endmodule

// File: tb/tb_sram_1rw1r_responder.sv
// Directed bench for sram_1rw1r_responder: clear timing, table of access vectors,
// hold behaviour and reset during clear.
module tb_sram_1rw1r_responder;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int NV = 13;

    typedef struct packed {
        logic          csb0;
        logic          web0;
        logic          wmask0;
        logic [AW-1:0] addr0;
        logic [DW-1:0] din0;
        logic          csb1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic          ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    sram_1rw1r_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_1rw1r_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic vec_t mk(input logic c0, input logic w0, input logic m0,
                                input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic c1, input logic [AW-1:0] a1,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                input logic ec);
        vec_t v;
        v.csb0 = c0; v.web0 = w0; v.wmask0 = m0; v.addr0 = a0; v.din0 = d0;
        v.csb1 = c1; v.addr1 = a1; v.e0 = e0; v.e1 = e1; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic c0, input logic w0, input logic m0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic c1, input logic [AW-1:0] a1);
        @(negedge clk);
        bus.csb0 = c0; bus.web0 = w0; bus.wmask0 = m0; bus.addr0 = a0; bus.din0 = d0;
        bus.csb1 = c1; bus.addr1 = a1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs;
        return {15'd0, bus.dout0, bus.dout1, bus.collision};
    endfunction

    // Releases reset and counts edges until busy drops; douts/collision must stay 0 throughout.
    task automatic release_and_count(input string nm);
        int  n;
        logic dirty;
        n = 0;
        dirty = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            n++;
            if (bus.busy && (bus.dout0 !== '0 || bus.dout1 !== '0 || bus.collision !== 1'b0))
                dirty = 1'b1;
            if (bus.busy !== 1'b1) break;
        end
        chk({nm, "_busy_cycles"}, n, 32);
        chk({nm, "_clear_outs"}, {31'd0, dirty}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(0, 0, 1, 5'd3,  8'hA5, 1, 5'd0,  8'h00, 8'h00, 0);
        tbl[1]  = mk(0, 1, 0, 5'd3,  8'h00, 0, 5'd3,  8'hA5, 8'hA5, 0);
        tbl[2]  = mk(0, 0, 0, 5'd7,  8'h3C, 1, 5'd0,  8'hA5, 8'hA5, 0);
        tbl[3]  = mk(0, 1, 0, 5'd7,  8'h00, 1, 5'd0,  8'h00, 8'hA5, 0);
        tbl[4]  = mk(0, 0, 1, 5'd9,  8'h11, 0, 5'd7,  8'h00, 8'h00, 0);
        tbl[5]  = mk(0, 0, 1, 5'd9,  8'h22, 0, 5'd9,  8'h00, 8'h11, 1);
        tbl[6]  = mk(1, 1, 0, 5'd0,  8'h00, 0, 5'd9,  8'h00, 8'h22, 0);
        tbl[7]  = mk(0, 0, 0, 5'd9,  8'h55, 0, 5'd9,  8'h00, 8'h22, 0);
        tbl[8]  = mk(0, 0, 1, 5'd4,  8'h77, 0, 5'd5,  8'h00, 8'h00, 0);
        tbl[9]  = mk(0, 1, 0, 5'd4,  8'h00, 1, 5'd0,  8'h77, 8'h00, 0);
        tbl[10] = mk(0, 1, 0, 5'd31, 8'h00, 0, 5'd0,  8'h00, 8'h00, 0);
        tbl[11] = mk(0, 0, 1, 5'd31, 8'hFF, 0, 5'd31, 8'h00, 8'h00, 1);
        tbl[12] = mk(0, 1, 0, 5'd31, 8'h00, 0, 5'd3,  8'hFF, 8'hA5, 0);

        // Write attempts to addr 0 during reset and clear must be ignored.
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 1'b1; bus.addr0 = '0; bus.din0 = 8'hEE;
        bus.csb1 = 1'b0; bus.addr1 = '0;
        rst_n = 1'b0;
        step();
        step();
        chk("reset_state", {28'd0, bus.busy, bus.dout0 == '0, bus.dout1 == '0, bus.collision}, 32'hE);
        release_and_count("clear1");

        for (int a = 0; a < 32; a++) begin
            drive(0, 1, 0, a[AW-1:0], 8'h00, 0, a[AW-1:0]);
            step();
            chk($sformatf("zero_rd_%0d", a), {16'd0, bus.dout0, bus.dout1}, 0);
        end

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].csb0, tbl[i].web0, tbl[i].wmask0, tbl[i].addr0, tbl[i].din0,
                  tbl[i].csb1, tbl[i].addr1);
            step();
            chk($sformatf("vec_%0d", i), outs(), {15'd0, tbl[i].e0, tbl[i].e1, tbl[i].ec});
        end

        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 5'd0, 8'h00, 1, 5'd1);
            step();
            chk($sformatf("hold_%0d", k), outs(), {15'd0, 8'hFF, 8'hA5, 1'b0});
        end

        // Reset from READY must zero the outputs; then abort the clear at cycle 10.
        drive(0, 0, 1, 5'd0, 8'hEE, 0, 5'd0);
        rst_n = 1'b0;
        step();
        chk("reset_from_ready", outs(), 0);
        chk("busy_after_reset", {31'd0, bus.busy}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        chk("busy_mid_clear", {31'd0, bus.busy}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        step();
        release_and_count("clear2");

        drive(0, 1, 0, 5'd0, 8'h00, 0, 5'd3);
        step();
        chk("post_clear_rd", outs(), 0);
        drive(0, 1, 0, 5'd31, 8'h00, 0, 5'd9);
        step();
        chk("post_clear_rd2", outs(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
